// File: rtl/mtr_drv_if.sv
// Command and gate-drive bundle between the balance controller and the H-bridge driver.
// Commands are plain levels sampled at each PWM period boundary; synch is a one-clk strobe.
interface mtr_drv_if;
    logic        pwr_up;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        PWM1_lft;
    logic        PWM2_lft;
    logic        PWM1_rght;
    logic        PWM2_rght;
    logic        synch;

    modport master (
        output pwr_up, lft_spd, rght_spd,
        input  PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, synch
    );

    modport slave (
        input  pwr_up, lft_spd, rght_spd,
        output PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, synch
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual-side H-bridge PWM driver: 2048-clk period, boundary-latched duty,
// per-side non-overlap insertion and a period-start strobe.
module mtr_drv #(
    parameter int NONOVERLAP = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mtr_drv_if.slave  bus
);

    localparam int             DTW     = (NONOVERLAP > 1) ? $clog2(NONOVERLAP) : 1;
    localparam logic [DTW-1:0] DT_LAST = DTW'(NONOVERLAP - 1);
    localparam logic [10:0]    DUTY_MID = 11'h400;

    // Index 0 is the left side, index 1 the right side.
    logic [1:0][11:0]    spd;
    logic [10:0]         cnt_q, cnt_d;
    logic [1:0][10:0]    duty_sh_q, duty_sh_d;
    logic [1:0]          raw_q, raw_d;
    logic [1:0][DTW-1:0] dt_q, dt_d;
    logic [1:0]          pwm1_q, pwm1_d;
    logic [1:0]          pwm2_q, pwm2_d;
    logic                synch_q, synch_d;
    logic [1:0]          tgl;

    assign spd = {bus.rght_spd, bus.lft_spd};

    // (spd >>> 1) + 0x400 in 11 bits only flips the sign bit of the shifted value.
    function automatic logic [10:0] duty_map(input logic [11:0] s);
        return {~s[11], s[10:1]};
    endfunction

    always_comb begin
        cnt_d     = cnt_q + 11'd1;
        synch_d   = (cnt_q == 11'd0);
        duty_sh_d = duty_sh_q;
        raw_d     = raw_q;
        dt_d      = dt_q;
        pwm1_d    = '0;
        pwm2_d    = '0;
        tgl       = '0;
        for (int s = 0; s < 2; s++) begin
            if (cnt_q == 11'h7FF) begin
                duty_sh_d[s] = bus.pwr_up ? duty_map(spd[s]) : DUTY_MID;
            end
            raw_d[s] = (cnt_q < duty_sh_q[s]);
            tgl[s]   = raw_d[s] ^ raw_q[s];
            // Any raw edge restarts the non-overlap window with both gates off.
            if (tgl[s]) begin
                dt_d[s] = '0;
            end else if (dt_q[s] != DT_LAST) begin
                dt_d[s] = dt_q[s] + DTW'(1);
            end
            pwm1_d[s] = bus.pwr_up & ~tgl[s] & (dt_q[s] == DT_LAST) &  raw_q[s];
            pwm2_d[s] = bus.pwr_up & ~tgl[s] & (dt_q[s] == DT_LAST) & ~raw_q[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            duty_sh_q <= {DUTY_MID, DUTY_MID};
            raw_q     <= '0;
            dt_q      <= '0;
            pwm1_q    <= '0;
            pwm2_q    <= '0;
            synch_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            duty_sh_q <= duty_sh_d;
            raw_q     <= raw_d;
            dt_q      <= dt_d;
            pwm1_q    <= pwm1_d;
            pwm2_q    <= pwm2_d;
            synch_q   <= synch_d;
        end
    end

    assign bus.PWM1_lft  = pwm1_q[0];
    assign bus.PWM2_lft  = pwm2_q[0];
    assign bus.PWM1_rght = pwm1_q[1];
    assign bus.PWM2_rght = pwm2_q[1];
    assign bus.synch     = synch_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: period-level reference model feeding a per-cycle expected queue,
// plus steady-state duty measurements and reset checks.
module tb_mtr_drv;

    localparam int NOV    = 32;
    localparam int PERIOD = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mtr_drv_if bus();

    mtr_drv #(.NONOVERLAP(NOV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected {synch, PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght} per cycle.
    logic [4:0] exp_q[$];

    // Stimulus state
    logic        pwr;
    logic [11:0] spd_l, spd_r;

    // Reference model state: sample index since reset, period duties, raw history
    int n;
    int d_cur[2];
    bit hist_l[$];
    bit hist_r[$];

    // Measurement accumulators
    int m_p1l, m_p2l, m_p1r, m_p2r, m_syn;

    function automatic int duty_of(input logic [11:0] spd);
        int s;
        s = int'($signed(spd));
        return (s - (s & 1)) / 2 + 1024;
    endfunction

    // A gate is on only when raw has held the gate's level for NOV+1 samples.
    function automatic bit stable(input bit h[$], input bit v);
        if (h.size() < NOV + 1) return 1'b0;
        foreach (h[i]) if (h[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        d_cur[0] = 1024;
        d_cur[1] = 1024;
        hist_l.delete();
        hist_r.delete();
        hist_l.push_back(1'b0);
        hist_r.push_back(1'b0);
    endtask

    // Called at a negedge: drives inputs, predicts the next sample, advances one clock.
    task automatic step();
        logic [4:0] e;
        int m;
        bus.pwr_up   = pwr;
        bus.lft_spd  = spd_l;
        bus.rght_spd = spd_r;
        m = (n + 1) % PERIOD;
        if (m == 0) begin
            d_cur[0] = pwr ? duty_of(spd_l) : 1024;
            d_cur[1] = pwr ? duty_of(spd_r) : 1024;
        end
        hist_l.push_back(bit'((m != 0) && ((m - 1) < d_cur[0])));
        hist_r.push_back(bit'((m != 0) && ((m - 1) < d_cur[1])));
        if (hist_l.size() > NOV + 1) void'(hist_l.pop_front());
        if (hist_r.size() > NOV + 1) void'(hist_r.pop_front());
        e[4] = (m == 1);
        e[3] = pwr & stable(hist_l, 1'b1);
        e[2] = pwr & stable(hist_l, 1'b0);
        e[1] = pwr & stable(hist_r, 1'b1);
        e[0] = pwr & stable(hist_r, 1'b0);
        exp_q.push_back(e);
        n++;
        @(negedge clk);
        m_p1l += int'(bus.PWM1_lft);
        m_p2l += int'(bus.PWM2_lft);
        m_p1r += int'(bus.PWM1_rght);
        m_p2r += int'(bus.PWM2_rght);
        m_syn += int'(bus.synch);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic measure(input string tag, input int p1l, input int p2l,
                           input int p1r, input int p2r);
        run(2 * PERIOD);
        m_p1l = 0; m_p2l = 0; m_p1r = 0; m_p2r = 0; m_syn = 0;
        run(PERIOD);
        check({tag, "_pwm1_lft"},  m_p1l, p1l);
        check({tag, "_pwm2_lft"},  m_p2l, p2l);
        check({tag, "_pwm1_rght"}, m_p1r, p1r);
        check({tag, "_pwm2_rght"}, m_p2r, p2r);
        check({tag, "_synch"},     m_syn, 1);
    endtask

    function automatic logic [11:0] rand_spd();
        int dd;
        case ($urandom_range(0, 4))
            0: return 12'h7FF;
            1: return 12'h800;
            2: begin
                dd = $urandom_range(20, 45);
                return 12'(2 * (dd - 1024));
            end
            3: begin
                dd = $urandom_range(2000, 2030);
                return 12'(2 * (dd - 1024) + 1);
            end
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    // Monitor: one expected entry per clock while out of reset
    initial begin
        logic [4:0] e, got;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.synch, bus.PWM1_lft, bus.PWM2_lft, bus.PWM1_rght, bus.PWM2_rght};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t got=%b exp=%b", $time, got, e);
                end
            end
        end
    end

    // Shoot-through guard on every cycle
    always @(negedge clk) begin
        vectors++;
        if ((bus.PWM1_lft & bus.PWM2_lft) | (bus.PWM1_rght & bus.PWM2_rght)) begin
            miscompares++;
            $display("FAIL overlap t=%0t lft=%b%b rght=%b%b", $time,
                     bus.PWM1_lft, bus.PWM2_lft, bus.PWM1_rght, bus.PWM2_rght);
        end
    end

    initial begin
        pwr = 1'b1; spd_l = 12'h000; spd_r = 12'h000;
        bus.pwr_up = pwr; bus.lft_spd = spd_l; bus.rght_spd = spd_r;
        m_p1l = 0; m_p2l = 0; m_p1r = 0; m_p2r = 0; m_syn = 0;
        #1 rst_n = 1'b0;
        #22;
        check("rst_pwm1_lft",  int'(bus.PWM1_lft),  0);
        check("rst_pwm2_lft",  int'(bus.PWM2_lft),  0);
        check("rst_pwm1_rght", int'(bus.PWM1_rght), 0);
        check("rst_pwm2_rght", int'(bus.PWM2_rght), 0);
        check("rst_synch",     int'(bus.synch),     0);

        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Right command changes mid-period at cnt==500
        while ((n % PERIOD) != 500) step();
        spd_r = 12'h400;
        measure("mid50_r1536", 992, 992, 1504, 480);

        // Asynchronous reset while PWM1_lft is high
        while ((n % PERIOD) != 600) step();
        check("pre_rst_pwm1_lft", int'(bus.PWM1_lft), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs",
              int'({bus.synch, bus.PWM1_lft, bus.PWM2_lft, bus.PWM1_rght, bus.PWM2_rght}), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        spd_l = 12'h7FF; spd_r = 12'h800;
        measure("max_min", 2015, 0, 0, 2048);

        spd_l = 12'h800; spd_r = 12'h7FF;
        measure("min_max", 0, 2048, 2015, 0);

        while ((n % PERIOD) != 900) step();
        pwr = 1'b0;
        measure("pwr_off", 0, 0, 0, 0);

        // Randomized commands, including near-dead-time pulses and power toggles
        pwr = 1'b1;
        repeat (6 * PERIOD) begin
            if ($urandom_range(0, 699) == 0) spd_l = rand_spd();
            if ($urandom_range(0, 699) == 0) spd_r = rand_spd();
            if ($urandom_range(0, 2999) == 0) pwr = ~pwr;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
